// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b - bin.
// One full-subtractor cell is applied per clock, LSB first. The borrow is kept in
// a register between bits. One operation takes WIDTH busy cycles and is followed
// by a one-cycle done pulse.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      sample a/b/bin; accepted only in IDLE or DONE
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   bin    in   1      borrow-in
//   busy   out  1      high while shifting
//   done   out  1      one-cycle pulse: diff/bout hold a new result
//   diff   out  WIDTH  result register, held until the next completion
//   bout   out  1      final borrow (a < b + bin, unsigned)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    // Result bits produced so far, left-aligned; the final bit completes them.
    logic [WIDTH-2:0] sd_q, sd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    // Full-subtractor cell on the current LSBs.
    logic             x, y, dbit, br_next;
    logic [WIDTH-1:0] sd_cat;

    always_comb begin
        x       = sa_q[0];
        y       = sb_q[0];
        dbit    = x ^ y ^ br_q;
        br_next = (~x & y) | (~(x ^ y) & br_q);
        sd_cat  = {dbit, sd_q};
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sd_d    = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_cat[WIDTH-1:1];
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    diff_d  = sd_cat;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Status outputs are decoded straight from the state register.
    assign busy = (state_q == StBusy);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start3 = 1'b0, bin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, bout3;
    logic [2:0] diff3;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [3:0] q3[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {borrow, diff} is the (WIDTH+1)-bit value of a - b - bin.
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic bin);
        return {1'b0, a} - {1'b0, b} - 9'(bin);
    endfunction

    function automatic logic [3:0] model3(input logic [2:0] a, input logic [2:0] b,
                                          input logic bin);
        return {1'b0, a} - {1'b0, b} - 4'(bin);
    endfunction

    // Monitors: pop one expected result per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy8 && done8) check("busy8_and_done8", 1, 0);
            if (done8) begin
                if (q8.size() == 0) check("unexpected_done8", 1, 0);
                else check("result8", {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy3 && done3) check("busy3_and_done3", 1, 0);
            if (done3) begin
                if (q3.size() == 0) check("unexpected_done3", 1, 0);
                else check("result3", {28'd0, bout3, diff3}, {28'd0, q3.pop_front()});
            end
        end
    end

    // Called at the negedge after the start edge; returns at the done negedge.
    task automatic wait_done8(input int exp_busy);
        int n = 0;
        int guard = 0;
        while (!done8 && guard < 40) begin
            if (busy8) n++;
            guard++;
            @(negedge clk);
        end
        check("done8_seen", 32'(done8), 1);
        check("busy8_cycles", n, exp_busy);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        q8.push_back(model8(a, b, bin));
        @(negedge clk);
        start8 = 1'b0;
        // Operands may change freely once sampled.
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8(8);
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic bin);
        int guard = 0;
        @(negedge clk);
        start3 = 1'b1; a3 = a; b3 = b; bin3 = bin;
        q3.push_back(model3(a, b, bin));
        @(negedge clk);
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
        while (!done3 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("done3_latency", guard, 3);
    endtask

    initial begin
        int cyc;
        logic [7:0] ra, rb;
        logic       rbin;

        #1 rst = 1'b1;
        #1;
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_diff8", 32'(diff8), 0);
        check("rst_bout8", 32'(bout8), 0);
        check("rst_busy3", 32'(busy3), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run8(8'h05, 8'h03, 1'b0);
        run8(8'h03, 8'h05, 1'b0);
        run8(8'h00, 8'h00, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0);
        run8(8'h80, 8'h7F, 1'b1);
        run8(8'hFF, 8'h00, 1'b1);

        // Random cases
        for (int i = 0; i < 40; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Start held high: one result every WIDTH+1 cycles
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        start8 = 1'b1; a8 = ra; b8 = rb; bin8 = rbin;
        q8.push_back(model8(ra, rb, rbin));
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done8 && cyc < 40);
            check("b2b_period", cyc, 9);
            if (k < 3) begin
                ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
                a8 = ra; b8 = rb; bin8 = rbin;
                q8.push_back(model8(ra, rb, rbin));
            end else begin
                start8 = 1'b0;
            end
        end

        // Start pulsed during BUSY is ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0;
        q8.push_back(9'h01F);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("ign_done_seen", 32'(done8), 1);
        repeat (3) @(negedge clk);
        check("ign_no_reload", 32'(busy8), 0);

        // Reset in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h0F; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy8), 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy8", 32'(busy8), 0);
        check("midrst_done8", 32'(done8), 0);
        check("midrst_diff8", 32'(diff8), 0);
        check("midrst_bout8", 32'(bout8), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_idle", 32'(busy8), 0);
        check("post_rst_diff", 32'(diff8), 0);
        run8(8'h20, 8'h21, 1'b0);

        // WIDTH=3 exhaustive
        for (int i = 0; i < 128; i++) begin
            run3(i[2:0], i[5:3], i[6]);
        end

        repeat (5) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
